// File: rtl/pic_pkg.sv
// Shared types and level encode/decode helpers for the 8259A-style
// interrupt acknowledge path.
package pic_pkg;

   localparam int NUM_LEVELS = 8;

   typedef logic [2:0] level_t;

   typedef enum logic [2:0] {
      IDLE,
      REQUEST,
      ACK1,
      WAIT2,
      ACK2
   } ack_state_t;

   // Level reported when the request vanishes under the first INTA pulse.
   localparam level_t SPURIOUS_LEVEL = 3'd7;

   function automatic level_t onehot_to_level(input logic [NUM_LEVELS-1:0] onehot);
      level_t lvl;
      lvl = '0;
      for (int i = 0; i < NUM_LEVELS; i++) begin
         if (onehot[i]) lvl = level_t'(i);
      end
      return lvl;
   endfunction

   function automatic logic [NUM_LEVELS-1:0] level_to_onehot(input level_t lvl);
      return 8'b1 << lvl;
   endfunction

endpackage

// File: rtl/in_service_clear_selector.sv
// Picks the in-service bit an EOI command retires: either the named level or
// the highest-priority set bit relative to the rotation reference.
module in_service_clear_selector
   import pic_pkg::*;
(
   input  logic [7:0] isr,
   input  level_t     lowest_priority_level,
   input  logic       eoi_specific,
   input  level_t     eoi_level,
   output logic [7:0] clear_mask,
   output level_t     cleared_level,
   output logic       clear_valid
);

   level_t w_scan_idx;

   always_comb begin
      cleared_level = '0;
      clear_valid   = 1'b0;
      w_scan_idx    = '0;
      if (eoi_specific) begin
         cleared_level = eoi_level;
         clear_valid   = isr[eoi_level];
      end else begin
         // Walk lowest-priority order first so the highest-priority hit lands last.
         for (int i = NUM_LEVELS; i >= 1; i--) begin
            w_scan_idx = lowest_priority_level + level_t'(i);
            if (isr[w_scan_idx]) begin
               cleared_level = w_scan_idx;
               clear_valid   = 1'b1;
            end
         end
      end
      clear_mask = clear_valid ? level_to_onehot(cleared_level) : 8'h00;
   end

endmodule

// File: rtl/interrupt_acknowledge_sequencer.sv
// Raises INT for the resolver's winner, runs the two-pulse INTA handshake,
// owns the ISR and rotation reference, and drives the vector byte.
//
// state   | meaning
// IDLE    | no request outstanding, INT low
// REQUEST | INT high, waiting for first INTA fall
// ACK1    | inside first INTA pulse, level latched
// WAIT2   | between pulses, waiting for second fall
// ACK2    | vector on the bus until second INTA rise
module interrupt_acknowledge_sequencer
   import pic_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] interrupt,
   input  logic       inta_n,
   input  logic [4:0] vector_base,
   input  logic       auto_eoi,
   input  logic       rotate_on_aeoi,
   input  logic       eoi_strobe,
   input  logic       eoi_specific,
   input  logic [2:0] eoi_level,
   input  logic       eoi_rotate,
   output logic       int_out,
   output logic [7:0] in_service_register,
   output logic [7:0] clear_interrupt_request,
   output logic [2:0] lowest_priority_level,
   output logic [7:0] data_out,
   output logic       data_out_enable
);

   ack_state_t r_state;
   logic       r_inta_q;
   level_t     r_level;
   logic       r_int_out;
   logic [7:0] r_isr;
   logic [7:0] r_clr_req;
   level_t     r_lpl;
   logic [7:0] r_data_out;
   logic       r_data_oe;

   logic       w_fall;
   logic       w_rise;
   logic       w_req_any;
   level_t     w_req_level;
   logic [7:0] w_set_mask;
   logic       w_aeoi_fire;
   logic [7:0] w_aeoi_mask;
   logic [7:0] w_sel_mask;
   level_t     w_sel_level;
   logic       w_sel_valid;
   logic       w_eoi_fire;
   logic [7:0] w_eoi_mask;
   logic [7:0] w_isr_next;

   in_service_clear_selector u_clear_sel (
      .isr                   (r_isr),
      .lowest_priority_level (r_lpl),
      .eoi_specific          (eoi_specific),
      .eoi_level             (eoi_level),
      .clear_mask            (w_sel_mask),
      .cleared_level         (w_sel_level),
      .clear_valid           (w_sel_valid)
   );

   assign w_fall      = r_inta_q & ~inta_n;
   assign w_rise      = ~r_inta_q & inta_n;
   assign w_req_any   = |interrupt;
   assign w_req_level = w_req_any ? onehot_to_level(interrupt) : SPURIOUS_LEVEL;

   assign w_set_mask  = (r_state == REQUEST && w_fall && w_req_any) ?
                        level_to_onehot(w_req_level) : 8'h00;
   assign w_aeoi_fire = (r_state == ACK2) && w_rise && auto_eoi;
   assign w_aeoi_mask = w_aeoi_fire ? level_to_onehot(r_level) : 8'h00;
   assign w_eoi_fire  = eoi_strobe & w_sel_valid;
   assign w_eoi_mask  = w_eoi_fire ? w_sel_mask : 8'h00;

   // A set on the same bit as a clear wins.
   assign w_isr_next  = (r_isr & ~(w_aeoi_mask | w_eoi_mask)) | w_set_mask;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= IDLE;
         r_inta_q   <= 1'b1;
         r_level    <= '0;
         r_int_out  <= 1'b0;
         r_isr      <= 8'h00;
         r_clr_req  <= 8'h00;
         r_lpl      <= 3'd7;
         r_data_out <= 8'h00;
         r_data_oe  <= 1'b0;
      end else begin
         r_inta_q  <= inta_n;
         r_isr     <= w_isr_next;
         r_clr_req <= 8'h00;

         if (w_eoi_fire && eoi_rotate) begin
            r_lpl <= w_sel_level;
         end else if (w_aeoi_fire && rotate_on_aeoi) begin
            r_lpl <= r_level;
         end

         case (r_state)
            IDLE: begin
               if (w_req_any) begin
                  r_int_out <= 1'b1;
                  r_state   <= REQUEST;
               end
            end
            REQUEST: begin
               if (w_fall) begin
                  r_level   <= w_req_level;
                  r_clr_req <= w_set_mask;
                  r_int_out <= 1'b0;
                  r_state   <= ACK1;
               end else if (!w_req_any) begin
                  r_int_out <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            ACK1: begin
               if (w_rise) r_state <= WAIT2;
            end
            WAIT2: begin
               if (w_fall) begin
                  r_data_out <= {vector_base, r_level};
                  r_data_oe  <= 1'b1;
                  r_state    <= ACK2;
               end
            end
            ACK2: begin
               if (w_rise) begin
                  r_data_oe <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign int_out                 = r_int_out;
   assign in_service_register     = r_isr;
   assign clear_interrupt_request = r_clr_req;
   assign lowest_priority_level   = r_lpl;
   assign data_out                = r_data_out;
   assign data_out_enable         = r_data_oe;

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// Directed handshake/EOI scenarios followed by randomized traffic, all checked
// every cycle against a behavioural model of the acknowledge sequencer.
module tb_interrupt_acknowledge_sequencer;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] interrupt;
   logic       inta_n;
   logic [4:0] vector_base;
   logic       auto_eoi;
   logic       rotate_on_aeoi;
   logic       eoi_strobe;
   logic       eoi_specific;
   logic [2:0] eoi_level;
   logic       eoi_rotate;
   logic       int_out;
   logic [7:0] in_service_register;
   logic [7:0] clear_interrupt_request;
   logic [2:0] lowest_priority_level;
   logic [7:0] data_out;
   logic       data_out_enable;

   always #5 clock = ~clock;

   interrupt_acknowledge_sequencer dut (
      .clock                   (clock),
      .reset                   (reset),
      .interrupt               (interrupt),
      .inta_n                  (inta_n),
      .vector_base             (vector_base),
      .auto_eoi                (auto_eoi),
      .rotate_on_aeoi          (rotate_on_aeoi),
      .eoi_strobe              (eoi_strobe),
      .eoi_specific            (eoi_specific),
      .eoi_level               (eoi_level),
      .eoi_rotate              (eoi_rotate),
      .int_out                 (int_out),
      .in_service_register     (in_service_register),
      .clear_interrupt_request (clear_interrupt_request),
      .lowest_priority_level   (lowest_priority_level),
      .data_out                (data_out),
      .data_out_enable         (data_out_enable)
   );

   int n_pass  = 0;
   int n_total = 0;

   // Model: m_pulses counts handshake progress as "INTA pulses seen so far".
   logic       m_int;
   logic [7:0] m_isr;
   logic [7:0] m_clr;
   logic [2:0] m_lpl;
   logic [7:0] m_dout;
   logic       m_oe;
   logic       m_inta_prev;
   logic       m_pending;
   int         m_pulses;
   int         m_level;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
   endtask

   task automatic model_update();
      logic       fall, rise;
      logic [7:0] set_m, clr_m;
      int         eoi_lvl;
      logic       eoi_hit, aeoi_rot;
      if (reset) begin
         m_int = 0; m_isr = 0; m_clr = 0; m_lpl = 7; m_dout = 0; m_oe = 0;
         m_inta_prev = 1; m_pending = 0; m_pulses = 0; m_level = 0;
         return;
      end
      fall = m_inta_prev && !inta_n;
      rise = !m_inta_prev && inta_n;
      set_m = 0; clr_m = 0; aeoi_rot = 0; eoi_hit = 0; eoi_lvl = 0;
      m_clr = 0;
      if (!m_pending) begin
         if (interrupt != 0) begin m_pending = 1; m_pulses = 0; m_int = 1; end
      end else if (m_pulses == 0) begin
         if (fall) begin
            m_level = 7;
            for (int k = 0; k < 8; k++) if (interrupt[k]) m_level = k;
            if (interrupt != 0) set_m = 8'(1 << m_level);
            m_clr = set_m;
            m_int = 0;
            m_pulses = 1;
         end else if (interrupt == 0) begin
            m_int = 0; m_pending = 0;
         end
      end else if (m_pulses == 1) begin
         if (rise) m_pulses = 2;
      end else if (m_pulses == 2) begin
         if (fall) begin
            m_dout = 8'(vector_base * 8 + m_level);
            m_oe = 1;
            m_pulses = 3;
         end
      end else begin
         if (rise) begin
            m_oe = 0;
            if (auto_eoi) begin
               clr_m = 8'(1 << m_level);
               aeoi_rot = rotate_on_aeoi;
            end
            m_pending = 0;
            m_pulses = 0;
         end
      end
      if (eoi_strobe) begin
         if (eoi_specific) begin
            eoi_lvl = int'(eoi_level);
            eoi_hit = m_isr[eoi_level];
         end else begin
            for (int k = 1; k <= 8; k++) begin
               int idx = (int'(m_lpl) + k) % 8;
               if (!eoi_hit && m_isr[idx]) begin eoi_hit = 1; eoi_lvl = idx; end
            end
         end
         if (eoi_hit) clr_m = clr_m | 8'(1 << eoi_lvl);
      end
      if (eoi_hit && eoi_rotate) m_lpl = 3'(eoi_lvl);
      else if (aeoi_rot) m_lpl = 3'(m_level);
      m_isr = (m_isr & ~clr_m) | set_m;
      m_inta_prev = inta_n;
   endtask

   task automatic compare_all();
      chk("int_out",   32'(int_out),                 32'(m_int));
      chk("isr",       32'(in_service_register),     32'(m_isr));
      chk("irr_clear", 32'(clear_interrupt_request), 32'(m_clr));
      chk("lpl",       32'(lowest_priority_level),   32'(m_lpl));
      chk("data_out",  32'(data_out),                32'(m_dout));
      chk("data_oe",   32'(data_out_enable),         32'(m_oe));
   endtask

   task automatic tick();
      @(posedge clock);
      model_update();
      @(negedge clock);
      compare_all();
   endtask

   task automatic do_ack(input logic [7:0] req);
      interrupt = req; tick();
      inta_n = 0;      tick();
      interrupt = 0;   tick();
      inta_n = 1;      tick();
      inta_n = 0;      tick();
      inta_n = 1;      tick();
   endtask

   task automatic do_eoi(input logic spec, input logic [2:0] lvl, input logic rot);
      eoi_strobe = 1; eoi_specific = spec; eoi_level = lvl; eoi_rotate = rot;
      tick();
      eoi_strobe = 0; eoi_rotate = 0;
      tick();
   endtask

   initial begin
      int r;
      reset = 1; interrupt = 0; inta_n = 1; vector_base = 5'b01000;
      auto_eoi = 0; rotate_on_aeoi = 0; eoi_strobe = 0; eoi_specific = 0;
      eoi_level = 0; eoi_rotate = 0;
      tick(); tick();
      chk("rst_lpl", 32'(lowest_priority_level), 32'd7);
      chk("rst_isr", 32'(in_service_register), 32'h0);
      reset = 0; tick();

      // Basic handshake, level 4, vector base 01000.
      interrupt = 8'b0001_0000; tick();
      chk("basic_int_hi", 32'(int_out), 32'd1);
      inta_n = 0; tick();
      chk("basic_int_lo", 32'(int_out), 32'd0);
      chk("basic_isr", 32'(in_service_register), 32'h10);
      chk("basic_clr", 32'(clear_interrupt_request), 32'h10);
      chk("basic_oe1", 32'(data_out_enable), 32'd0);
      interrupt = 0; tick();
      chk("basic_clr_once", 32'(clear_interrupt_request), 32'h0);
      inta_n = 1; tick();
      inta_n = 0; tick();
      chk("basic_vec", 32'(data_out), 32'h44);
      chk("basic_oe2", 32'(data_out_enable), 32'd1);
      inta_n = 1; tick();
      chk("basic_oe_off", 32'(data_out_enable), 32'd0);
      chk("basic_isr_kept", 32'(in_service_register), 32'h10);

      // AEOI with rotation on level 2.
      auto_eoi = 1; rotate_on_aeoi = 1;
      do_ack(8'b0000_0100);
      chk("aeoi_isr", 32'(in_service_register), 32'h10);
      chk("aeoi_lpl", 32'(lowest_priority_level), 32'd2);
      auto_eoi = 0; rotate_on_aeoi = 0;

      // Specific rotate on 4 sets the reference to 4, then build ISR=0x91.
      do_eoi(1, 3'd4, 1);
      chk("ref4_lpl", 32'(lowest_priority_level), 32'd4);
      do_ack(8'h01); do_ack(8'h10); do_ack(8'h80);
      chk("build_isr", 32'(in_service_register), 32'h91);
      do_eoi(0, 3'd0, 0);
      chk("ns_eoi_lpl4", 32'(in_service_register), 32'h11);
      do_ack(8'h80);
      do_eoi(1, 3'd7, 1);
      chk("ref7_lpl", 32'(lowest_priority_level), 32'd7);
      do_eoi(0, 3'd0, 0);
      chk("ns_eoi_lpl7", 32'(in_service_register), 32'h10);
      do_ack(8'h01);
      do_eoi(1, 3'd4, 1);
      chk("spec_isr", 32'(in_service_register), 32'h01);
      chk("spec_lpl", 32'(lowest_priority_level), 32'd4);
      do_eoi(1, 3'd4, 1);
      chk("spec_empty_isr", 32'(in_service_register), 32'h01);
      chk("spec_empty_lpl", 32'(lowest_priority_level), 32'd4);

      // Spurious: request withdrawn in the first-fall cycle.
      interrupt = 8'h08; tick();
      inta_n = 0; interrupt = 0; tick();
      chk("spur_isr", 32'(in_service_register), 32'h01);
      chk("spur_clr", 32'(clear_interrupt_request), 32'h0);
      inta_n = 1; tick();
      inta_n = 0; tick();
      chk("spur_vec", 32'(data_out), 32'h47);
      chk("spur_oe", 32'(data_out_enable), 32'd1);
      inta_n = 1; tick();

      // Reset while waiting for the second pulse.
      interrupt = 8'h02; tick();
      inta_n = 0; tick();
      interrupt = 0; inta_n = 1; tick();
      reset = 1; tick();
      chk("mid_rst_isr", 32'(in_service_register), 32'h0);
      chk("mid_rst_dout", 32'(data_out), 32'h0);
      chk("mid_rst_lpl", 32'(lowest_priority_level), 32'd7);
      reset = 0; inta_n = 0; tick();
      chk("mid_rst_no_oe", 32'(data_out_enable), 32'd0);
      inta_n = 1; tick();

      // Randomized traffic.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            r = int'($urandom_range(0, 9));
            interrupt = (r >= 8) ? 8'h00 : (8'b1 << r);
         end
         if ($urandom_range(0, 2) == 0) inta_n = ~inta_n;
         eoi_strobe   = ($urandom_range(0, 9) == 0);
         eoi_specific = 1'($urandom_range(0, 1));
         eoi_level    = 3'($urandom_range(0, 7));
         eoi_rotate   = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 99) == 0) begin
            auto_eoi       = 1'($urandom_range(0, 1));
            rotate_on_aeoi = 1'($urandom_range(0, 1));
            vector_base    = 5'($urandom_range(0, 31));
         end
         reset = ($urandom_range(0, 299) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/interrupt_acknowledge_sequencer.md
Name: interrupt_acknowledge_sequencer

Overview:
- Consumer end of the priority resolver output in the 8259A core.
- Takes the resolver's one-hot winning request and raises INT to the CPU.
- Runs the two-pulse 8086 INTA handshake, sets the in-service register (ISR) and drives the interrupt vector.
- Processes EOI commands and maintains the rotating-priority reference. The resolver consumes that reference and the ISR.

Parameters:
- NUM_LEVELS, 8, number of interrupt levels; the design is fixed at 8 and the width is 3-bit encoded.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- interrupt  in  8  one-hot winning request from the priority resolver; 0 = none.
- inta_n  in  1  CPU acknowledge strobe, active low, level, pre-synchronised.
- vector_base  in  5  T7..T3 from ICW2.
- auto_eoi  in  1  AEOI mode from ICW4.
- rotate_on_aeoi  in  1  rotate priority when AEOI clears a level.
- eoi_strobe  in  1  one-cycle OCW2 EOI command.
- eoi_specific  in  1  1 = specific EOI, 0 = non-specific.
- eoi_level  in  3  level for specific EOI.
- eoi_rotate  in  1  rotate priority on this EOI.
- int_out  out  1  INT to CPU.
- in_service_register  out  8  ISR.
- clear_interrupt_request  out  8  one-cycle one-hot pulse that clears the IRR bit.
- lowest_priority_level  out  3  rotation reference; priority starts at lowest_priority_level+1 mod 8.
- data_out  out  8  vector byte.
- data_out_enable  out  1  bus drive enable.

Behaviour:
- Reset values: int_out=0, ISR=0, clear_interrupt_request=0, lowest_priority_level=7, data_out=0, data_out_enable=0, state=IDLE, inta_n sample register=1.
- Edge detection: inta_n is registered as inta_q.
  - fall = inta_q & ~inta_n.
  - rise = ~inta_q & inta_n.
  - All actions are registered at the clock edge where the edge is detected.
- FSM states: IDLE, REQUEST, ACK1, WAIT2, ACK2.
- IDLE: if interrupt != 0, go to REQUEST; int_out=1 from the next cycle.
- REQUEST:
  - If interrupt returns to 0 before fall, int_out=0 next cycle and go to IDLE.
  - On fall:
    - Latch level = encode(interrupt).
    - Set ISR[level].
    - Pulse clear_interrupt_request[level] for exactly 1 cycle.
    - int_out=0.
    - Go to ACK1.
  - Spurious case: if interrupt==0 in the fall cycle, latch level 7, do not set ISR, do not pulse the IRR clear.
- ACK1: on rise, go to WAIT2. data_out_enable stays 0 during the first pulse.
- WAIT2: on fall, data_out={vector_base, level}, data_out_enable=1, go to ACK2.
- ACK2: on rise:
  - data_out_enable=0.
  - If auto_eoi, clear ISR[level]; if auto_eoi and rotate_on_aeoi, lowest_priority_level=level.
  - Go to IDLE; a new request can be raised from the next cycle.
- EOI handling (eoi_strobe, any state):
  - Specific EOI: clear ISR[eoi_level].
  - Non-specific EOI: clear the highest-priority set ISR bit. Scan order is lowest_priority_level+1 up to lowest_priority_level, mod 8.
  - If eoi_rotate, lowest_priority_level = the cleared level.
  - ISR empty or bit already 0: no ISR change and no rotation.
- ISR update rule: ISR_next = (ISR & ~clear_mask) | set_mask, evaluated in the same cycle.
  - If set and clear target the same bit in one cycle, set wins.
  - AEOI clear and EOI clear in the same cycle combine by OR.
- Simultaneous rotation sources: if AEOI rotation and EOI rotation occur in the same cycle, the EOI command wins.
- inta_n edges outside the expected states are ignored.
- Reset at any state, including mid-handshake, returns everything to reset values immediately on the reset edge.

Decomposition:
- pic_pkg holds:
  - state enum: IDLE, REQUEST, ACK1, WAIT2, ACK2.
  - level_t (3-bit).
  - SPURIOUS_LEVEL=7.
  - function onehot_to_level.
  - function level_to_onehot.
- One sub-module, in_service_clear_selector.
  - Combinational.
  - Inputs: ISR, lowest_priority_level, eoi_specific, eoi_level.
  - Outputs: clear_mask and cleared_level, plus a valid flag.

Test Plan:
- Basic handshake, AEOI off:
  - Stimulus: vector_base=5'b01000, interrupt=8'b00010000, two INTA pulses.
  - Response: int_out=1, then 0 at the first fall; ISR=8'b00010000; clear_interrupt_request=8'b00010000 for 1 cycle; data_out=8'h44 with data_out_enable=1 only during the second pulse.
- Auto EOI with rotation:
  - Stimulus: auto_eoi=1, rotate_on_aeoi=1, interrupt=8'b00000100.
  - Response: ISR returns to 0 at the second rise; lowest_priority_level=2.
- Non-specific EOI with rotation reference:
  - Stimulus: ISR=8'b10010001, lowest_priority_level=4, non-specific EOI.
  - Response: bit 7 cleared, ISR=8'b00010001.
  - Then set lowest_priority_level=7 and issue another non-specific EOI: bit 0 cleared.
- Specific EOI with rotate:
  - Stimulus: eoi_level=4, eoi_rotate=1, ISR=8'b00010001.
  - Response: ISR=8'b00000001; lowest_priority_level=4.
  - Follow-up: specific EOI on an empty bit leaves ISR and rotation unchanged.
- Spurious acknowledge:
  - Stimulus: interrupt is withdrawn in the same cycle as the first fall.
  - Response: ISR unchanged; no IRR clear pulse; second pulse drives data_out=8'h47.
- Reset mid-handshake:
  - Stimulus: reset asserted in WAIT2.
  - Response: all outputs at reset values; a following second INTA pulse does not enable data_out.
